// File: rtl/mac_limb_multiplier.sv
// Multi-limb unsigned multiplier: product-scanning schedule feeding one 2-stage MAC.
// Each column's carry is folded into the accumulator as the next column's first product lands.
module mac_limb_multiplier #(
    parameter int limb_width = 27,
    parameter int n_limbs    = 8,
    parameter int acc_width  = 64
) (
    input  logic                              clk,
    input  logic                              aclr,
    input  logic                              start,
    input  logic [n_limbs*limb_width-1:0]     op_a,
    input  logic [n_limbs*limb_width-1:0]     op_b,
    output logic                              busy,
    output logic                              done,
    output logic [2*n_limbs*limb_width-1:0]   result
);

    localparam int OPW      = n_limbs * limb_width;
    localparam int KW       = $clog2(2 * n_limbs);
    localparam int IW       = $clog2(n_limbs);
    localparam int LAST_COL = 2 * n_limbs - 2;

    generate
        if (limb_width < 1 || limb_width > 27) begin : g_bad_limb
            $error("mac_limb_multiplier: limb_width must be in 1..27");
        end
        if (n_limbs < 2) begin : g_bad_nlimbs
            $error("mac_limb_multiplier: n_limbs must be >= 2");
        end
        if (acc_width < 2 * limb_width + $clog2(n_limbs) + 1) begin : g_bad_acc
            $error("mac_limb_multiplier: acc_width too small for column sums");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // First and last multiplicand limb index contributing to column k.
    function automatic int col_lo(input int k);
        return (k > n_limbs - 1) ? (k - n_limbs + 1) : 0;
    endfunction

    function automatic int col_hi(input int k);
        return (k < n_limbs - 1) ? k : (n_limbs - 1);
    endfunction

    state_t state_q, state_d;

    logic [OPW-1:0]        op_a_r;
    logic [OPW-1:0]        op_b_r;
    logic [KW-1:0]         k_q, k_d;
    logic [IW-1:0]         i_q, i_d;
    logic                  drain_q;
    int                    k_int;
    int                    i_int;
    logic                  col_end;
    logic                  last_issue;
    logic                  accept;
    logic [limb_width-1:0] a_sel;
    logic [limb_width-1:0] b_sel;

    logic [limb_width-1:0] a_p0;
    logic [limb_width-1:0] b_p0;
    logic                  vld_p0;
    logic                  last_p0;
    logic [acc_width-1:0]  prod_p0;

    logic [acc_width-1:0]  acc_p1;
    logic                  close_pend_p1;
    logic [KW-1:0]         close_col_p1;

    assign accept = (state_q == S_IDLE) && start;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

    always_comb begin
        k_int      = int'(k_q);
        i_int      = int'(i_q);
        col_end    = (i_int == col_hi(k_int));
        last_issue = col_end && (k_int == LAST_COL);
        a_sel      = op_a_r[i_int*limb_width +: limb_width];
        b_sel      = op_b_r[(k_int-i_int)*limb_width +: limb_width];
        k_d        = k_q;
        i_d        = i_q + IW'(1);
        if (col_end) begin
            k_d = KW'(k_int + 1);
            i_d = IW'(col_lo(k_int + 1));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            i_q     <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == S_DRAIN) && !drain_q;
            if (accept) begin
                k_q <= '0;
                i_q <= '0;
            end else if (state_q == S_RUN) begin
                k_q <= k_d;
                i_q <= i_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_a_r <= op_a;
            op_b_r <= op_b;
        end
    end

    // ---- stage p0: operand registers, column-end tag rides along ----
    always_ff @(posedge clk) begin
        a_p0 <= a_sel;
        b_p0 <= b_sel;
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= (state_q == S_RUN);
            last_p0 <= col_end;
        end
    end

    assign prod_p0 = acc_width'(a_p0) * acc_width'(b_p0);

    // ---- stage p1: accumulate; a pending close retires one limb and carries the rest ----
    always_ff @(posedge clk) begin
        if (aclr) begin
            acc_p1        <= '0;
            close_pend_p1 <= 1'b0;
            close_col_p1  <= '0;
            result        <= '0;
        end else if (accept) begin
            acc_p1        <= '0;
            close_pend_p1 <= 1'b0;
            close_col_p1  <= '0;
        end else if (vld_p0) begin
            if (close_pend_p1) begin
                result[int'(close_col_p1)*limb_width +: limb_width] <= acc_p1[limb_width-1:0];
                acc_p1       <= (acc_p1 >> limb_width) + prod_p0;
                close_col_p1 <= close_col_p1 + KW'(1);
            end else begin
                acc_p1 <= acc_p1 + prod_p0;
            end
            close_pend_p1 <= last_p0;
        end else if ((state_q == S_DRAIN) && drain_q) begin
            // Top column closes here; whatever remains above it is the final limb.
            result[LAST_COL*limb_width +: limb_width]     <= acc_p1[limb_width-1:0];
            result[(LAST_COL+1)*limb_width +: limb_width] <= acc_p1[2*limb_width-1:limb_width];
            close_pend_p1 <= 1'b0;
        end
    end

endmodule
